mux_arbiter_2x1: RTL

MUX_ARBITER_2X1 -- requirements
Module: mux_arbiter_2x1

---
 rtl/mux_arbiter_2x1.sv | 100 ++++++++++
 1 files changed

// File: rtl/mux_arbiter_2x1.sv
// Two-requester arbiter with a registered 2:1 data mux and bounded bursts.
// Round-robin on ties; a requester keeps the grant for up to BURST_MAX beats while the other waits.
//
// state  | meaning
// IDLE   | no grant; waiting for a requester
// SERVE0 | requester 0 owns the mux
// SERVE1 | requester 1 owns the mux
module mux_arbiter_2x1 #(
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              sel
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } state_t;

  localparam int CW = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(BURST_MAX);

  state_t          state, state_nxt;
  logic            last_served;
  logic [CW-1:0]   cnt, cnt_inc;
  logic            can_accept, xfer0, xfer1, cnt_hit;

  assign can_accept = !out_valid || out_ready;
  assign req0_ready = (state == SERVE0) && can_accept;
  assign req1_ready = (state == SERVE1) && can_accept;
  assign xfer0      = req0_valid && req0_ready;
  assign xfer1      = req1_valid && req1_ready;
  assign sel        = (state == SERVE1);

  // Saturating increment; a transfer at saturation still counts as reaching the limit.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign cnt_hit = (cnt_inc == CNT_MAX);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req0_valid && req1_valid) state_nxt = last_served ? SERVE0 : SERVE1;
        else if (req0_valid)          state_nxt = SERVE0;
        else if (req1_valid)          state_nxt = SERVE1;
      end
      SERVE0: begin
        if (!req0_valid)                         state_nxt = req1_valid ? SERVE1 : IDLE;
        else if (xfer0 && cnt_hit && req1_valid) state_nxt = SERVE1;
      end
      SERVE1: begin
        if (!req1_valid)                         state_nxt = req0_valid ? SERVE0 : IDLE;
        else if (xfer1 && cnt_hit && req0_valid) state_nxt = SERVE0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      last_served <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)  cnt <= '0;
      else if (xfer0 || xfer1) cnt <= cnt_inc;
      if (state_nxt == SERVE0 && state != SERVE0) last_served <= 1'b0;
      if (state_nxt == SERVE1 && state != SERVE1) last_served <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (xfer0) begin
      out_valid <= 1'b1;
      out_data  <= req0_data;
    end else if (xfer1) begin
      out_valid <= 1'b1;
      out_data  <= req1_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
